// File: rtl/apb_bus_arbiter.sv
// rtl/apb_bus_arbiter.sv - round-robin arbiter and APB master sharing one bus between NREQ requesters
//
// Purpose:
//   Picks one pending requester per transfer in round-robin order.
//   Runs that request through the APB SETUP and ACCESS phases.
//   Returns a one-cycle done pulse to the requester, together with err and the read data.
//   A slave that never raises apb_ready is aborted after TIMEOUT ACCESS cycles.
//
// Ports:
//   clk, reset                 clock (rising edge); synchronous active-high reset
//   req, req_write             per-requester request (held until done) and direction
//   req_id, req_addr,          per-requester packed slices: 2-bit slave id (00 = none),
//   req_wdata                  address and write data
//   done, err, resp_rdata      one-hot completion pulse; error flag and read data valid with it
//   apb_sel, apb_write,        APB master outputs; apb_sel carries the slave id
//   apb_enable, apb_addr,      (00 = idle); apb_enable is high in ACCESS only
//   apb_wdata
//   apb_ready, apb_rdata       response from the selected slave
module apb_bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_write,
   input  logic [2*NREQ-1:0]  req_id,
   input  logic [AW*NREQ-1:0] req_addr,
   input  logic [DW*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]    done,
   output logic               err,
   output logic [DW-1:0]      resp_rdata,
   output logic [1:0]         apb_sel,
   output logic               apb_write,
   output logic               apb_enable,
   output logic [AW-1:0]      apb_addr,
   output logic [DW-1:0]      apb_wdata,
   input  logic               apb_ready,
   input  logic [DW-1:0]      apb_rdata
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt;
   logic [CW-1:0] tcnt;

   logic [PW-1:0] pick;
   logic          found;
   logic [1:0]    pick_id;
   int            idx;

   // Scan from the pointer, wrapping modulo NREQ. A requester whose done is
   // still high is skipped so it cannot win twice in a row.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx] && !done[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   assign pick_id = req_id[2*pick +: 2];

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
      return (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         gnt        <= '0;
         tcnt       <= '0;
         done       <= '0;
         err        <= 1'b0;
         resp_rdata <= '0;
         apb_sel    <= '0;
         apb_write  <= 1'b0;
         apb_enable <= 1'b0;
         apb_addr   <= '0;
         apb_wdata  <= '0;
      end else begin
         // done and err are single-cycle pulses
         done <= '0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt <= pick;
                  if (pick_id == 2'b00) begin
                     // No slave addressed: answer with an error without touching the bus
                     done[pick] <= 1'b1;
                     err        <= 1'b1;
                     ptr        <= next_ptr(pick);
                  end else begin
                     // The bus registers double as the latched copy of the request
                     apb_sel   <= pick_id;
                     apb_write <= req_write[pick];
                     apb_addr  <= req_addr[AW*pick +: AW];
                     apb_wdata <= req_wdata[DW*pick +: DW];
                     state     <= SETUP;
                  end
               end
            end
            SETUP: begin
               apb_enable <= 1'b1;
               tcnt       <= '0;
               state      <= ACCESS;
            end
            ACCESS: begin
               if (apb_ready || tcnt == CW'(TIMEOUT - 1)) begin
                  done[gnt] <= 1'b1;
                  err       <= !apb_ready;
                  if (apb_ready && !apb_write) resp_rdata <= apb_rdata;
                  apb_sel    <= '0;
                  apb_write  <= 1'b0;
                  apb_enable <= 1'b0;
                  apb_addr   <= '0;
                  apb_wdata  <= '0;
                  tcnt       <= '0;
                  ptr        <= next_ptr(gnt);
                  state      <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
